// File: rtl/ov7670_frame_arbiter_if.sv
// ov7670_frame_arbiter_if: camera/FIFO/reader signals between the frame arbiter and its neighbours
// master: arbiter side (drives OV_WRST, OV_WEN, READ_EN; samples OV_VSYNC, RD_FRAME)
// slave: pins/reader side (drives OV_VSYNC, RD_FRAME; samples the arbiter outputs)
interface ov7670_frame_arbiter_if;
    logic OV_VSYNC;
    logic RD_FRAME;
    logic OV_WRST;
    logic OV_WEN;
    logic READ_EN;
    modport master (input OV_VSYNC, RD_FRAME, output OV_WRST, OV_WEN, READ_EN);
    modport slave (output OV_VSYNC, RD_FRAME, input OV_WRST, OV_WEN, READ_EN);
endinterface

// File: rtl/ov7670_frame_arbiter.sv
// ov7670_frame_arbiter: arms the AL422 FIFO for one VSYNC-bounded frame, then hands it to the reader
// CLK_40M/RST: clock and synchronous active-high reset
// CFG_DONE: sensor configured; CAP_REQ: back-to-back capture enable
// bus: OV_VSYNC in, OV_WRST/OV_WEN out to FIFO write side, READ_EN out / RD_FRAME in to the reader
// FRAME_CNT: completed frames (wraps); ERR_TIMEOUT: sticky reader no-ack; BUSY: not idle
module ov7670_frame_arbiter #(
    parameter int SKIP_FRAMES = 2,
    parameter int WRST_CYCLES = 4,
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W = 16
) (
    input  logic CLK_40M,
    input  logic RST,
    input  logic CFG_DONE,
    input  logic CAP_REQ,
    ov7670_frame_arbiter_if.master bus,
    output logic [CNT_W-1:0] FRAME_CNT,
    output logic ERR_TIMEOUT,
    output logic BUSY
);
    localparam logic [2:0] IDLE = 3'd0, WAIT_VS = 3'd1, WRST = 3'd2, CAPTURE = 3'd3, REQ = 3'd4, READ = 3'd5;
    localparam int SW = $clog2(SKIP_FRAMES + 2);
    localparam int WW = $clog2(WRST_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [2:0] state, state_n;
    logic vs_s1, vs_s2, vs_s3, vs_rise;
    logic [SW-1:0] skip_cnt;
    logic [WW-1:0] wrst_cnt;
    logic [TW-1:0] to_cnt;
    logic wrst_done, timeout;
    assign vs_rise = vs_s2 & ~vs_s3;
    assign wrst_done = wrst_cnt == WW'(WRST_CYCLES - 1);
    assign timeout = to_cnt == TW'(ACK_TIMEOUT - 1);
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = CFG_DONE && CAP_REQ && skip_cnt == '0 ? WAIT_VS : IDLE;
            WAIT_VS: state_n = !CFG_DONE || !CAP_REQ ? IDLE : vs_rise ? WRST : WAIT_VS;
            WRST:    state_n = !CFG_DONE ? IDLE : wrst_done ? CAPTURE : WRST;
            CAPTURE: state_n = !CFG_DONE ? IDLE : vs_rise ? REQ : CAPTURE;
            REQ:     state_n = !bus.RD_FRAME ? READ : timeout ? IDLE : REQ;
            READ:    state_n = bus.RD_FRAME ? IDLE : READ;
            default: state_n = IDLE;
        endcase
    end
    // outputs are decoded from the next state so each one is a flop that changes with the transition
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            state       <= IDLE;
            vs_s1       <= 1'b0;
            vs_s2       <= 1'b0;
            vs_s3       <= 1'b0;
            skip_cnt    <= SW'(SKIP_FRAMES);
            wrst_cnt    <= '0;
            to_cnt      <= '0;
            bus.OV_WRST <= 1'b1;
            bus.OV_WEN  <= 1'b0;
            bus.READ_EN <= 1'b0;
            FRAME_CNT   <= '0;
            ERR_TIMEOUT <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_n;
            vs_s1       <= bus.OV_VSYNC;
            vs_s2       <= vs_s1;
            vs_s3       <= vs_s2;
            skip_cnt    <= !CFG_DONE ? SW'(SKIP_FRAMES) : skip_cnt != '0 && vs_rise ? skip_cnt - 1'b1 : skip_cnt;
            wrst_cnt    <= state == WRST ? wrst_cnt + 1'b1 : '0;
            to_cnt      <= state == REQ ? to_cnt + 1'b1 : '0;
            bus.OV_WRST <= state_n != WRST;
            bus.OV_WEN  <= state_n == CAPTURE;
            bus.READ_EN <= state_n == REQ;
            BUSY        <= state_n != IDLE;
            if (state == READ && bus.RD_FRAME)
                FRAME_CNT <= FRAME_CNT + 1'b1;
            if (state == REQ && bus.RD_FRAME && timeout)
                ERR_TIMEOUT <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ov7670_frame_arbiter.sv
// tb_ov7670_frame_arbiter: directed stimulus with an event scoreboard for ov7670_frame_arbiter
module tb_ov7670_frame_arbiter;
    localparam int K_WRST_LAT = 0, K_WRST_LEN = 1, K_WEN_LAT = 2, K_REN_LEN = 3, K_ERR = 4, K_CNT = 5;
    typedef struct {int k; int v;} ev_t;
    logic CLK_40M = 0, RST = 1, CFG_DONE = 0, CAP_REQ = 0;
    logic [3:0] FRAME_CNT;
    logic ERR_TIMEOUT, BUSY;
    ov7670_frame_arbiter_if bus();
    ov7670_frame_arbiter #(.CNT_W(4)) dut (
        .CLK_40M(CLK_40M), .RST(RST), .CFG_DONE(CFG_DONE), .CAP_REQ(CAP_REQ),
        .bus(bus), .FRAME_CNT(FRAME_CNT), .ERR_TIMEOUT(ERR_TIMEOUT), .BUSY(BUSY)
    );
    string kn [6] = '{"wrst_lat", "wrst_len", "wen_lat", "ren_len", "err", "cnt"};
    ev_t q[$];
    int checks = 0, errors = 0, cyc = 0, vs_cyc = 0, wl = 0, rh = 0;
    bit mon_en = 0, no_ack = 0;
    logic p_wrst = 1, p_wen = 0, p_ren = 0, p_err = 0;
    logic [3:0] p_cnt = 0;

    always #5 CLK_40M = ~CLK_40M;
    always @(posedge CLK_40M) cyc <= cyc + 1;

    task automatic push(input int k, input int v);
        ev_t e;
        e.k = k;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic obs(input int k, input int v);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %0d, expected no event", kn[k], v);
        end else begin
            e = q.pop_front();
            if (e.k != k || e.v != v) begin
                errors++;
                $display("FAIL %s: got %0d, expected %s=%0d", kn[k], v, kn[e.k], e.v);
            end
        end
    endtask

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, got, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge CLK_40M);
        #1;
    endtask

    task automatic vs_hi;
        @(posedge CLK_40M);
        #1 bus.OV_VSYNC = 1;
        vs_cyc = cyc;
        cyc_wait(10);
        bus.OV_VSYNC = 0;
    endtask

    task automatic chk_rst(input string n);
        chk({n, "_wrst"}, int'(bus.OV_WRST), 1);
        chk({n, "_wen"}, int'(bus.OV_WEN), 0);
        chk({n, "_ren"}, int'(bus.READ_EN), 0);
        chk({n, "_cnt"}, int'(FRAME_CNT), 0);
        chk({n, "_err"}, int'(ERR_TIMEOUT), 0);
        chk({n, "_busy"}, int'(BUSY), 0);
    endtask

    task automatic skip2;
        vs_hi;
        cyc_wait(60);
        chk("skip1_busy", int'(BUSY), 0);
        vs_hi;
        cyc_wait(60);
        chk("skip2_busy", int'(BUSY), 1);
    endtask

    task automatic frame(input int c);
        push(K_WRST_LAT, 3);
        push(K_WRST_LEN, 4);
        push(K_WEN_LAT, 3);
        push(K_REN_LEN, 3);
        push(K_CNT, c);
        vs_hi;
        cyc_wait(60);
        vs_hi;
        cyc_wait(60);
    endtask

    // reader: acknowledges two cycles after READ_EN, reads for 20 cycles
    initial begin
        bus.RD_FRAME = 1;
        forever begin
            @(negedge CLK_40M);
            if (bus.READ_EN === 1'b1 && !no_ack) begin
                repeat (2) @(posedge CLK_40M);
                #1 bus.RD_FRAME = 0;
                repeat (20) @(posedge CLK_40M);
                #1 bus.RD_FRAME = 1;
            end
        end
    end

    always @(negedge CLK_40M) begin
        if (mon_en) begin
            if (p_wrst === 1'b1 && bus.OV_WRST === 1'b0) obs(K_WRST_LAT, cyc - vs_cyc);
            if (p_wrst === 1'b0 && bus.OV_WRST === 1'b1) obs(K_WRST_LEN, wl);
            if (p_wen === 1'b1 && bus.OV_WEN === 1'b0) obs(K_WEN_LAT, cyc - vs_cyc);
            if (p_ren === 1'b1 && bus.READ_EN === 1'b0) obs(K_REN_LEN, rh);
            if (p_err === 1'b0 && ERR_TIMEOUT === 1'b1) obs(K_ERR, int'(FRAME_CNT));
            if (FRAME_CNT !== p_cnt) obs(K_CNT, int'(FRAME_CNT));
            if (bus.OV_WEN === 1'b1 && bus.READ_EN === 1'b1) begin
                errors++;
                $display("FAIL excl: OV_WEN=1 and READ_EN=1 at cycle %0d, required never both", cyc);
            end
        end
        wl = bus.OV_WRST === 1'b0 ? wl + 1 : 0;
        rh = bus.READ_EN === 1'b1 ? rh + 1 : 0;
        p_wrst = bus.OV_WRST;
        p_wen = bus.OV_WEN;
        p_ren = bus.READ_EN;
        p_err = ERR_TIMEOUT;
        p_cnt = FRAME_CNT;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.OV_VSYNC = 0;
        repeat (3) @(posedge CLK_40M);
        @(negedge CLK_40M);
        chk_rst("reset");
        cyc_wait(1);
        RST = 0;
        mon_en = 1;
        CFG_DONE = 1;
        CAP_REQ = 1;
        skip2;
        frame(1);
        frame(2);
        // reader never acknowledges
        no_ack = 1;
        push(K_WRST_LAT, 3);
        push(K_WRST_LEN, 4);
        push(K_WEN_LAT, 3);
        push(K_REN_LEN, 1024);
        push(K_ERR, 2);
        vs_hi;
        cyc_wait(60);
        vs_hi;
        cyc_wait(1100);
        chk("timeout_cnt", int'(FRAME_CNT), 2);
        no_ack = 0;
        frame(3);
        chk("err_sticky", int'(ERR_TIMEOUT), 1);
        // CAP_REQ dropped during capture
        push(K_WRST_LAT, 3);
        push(K_WRST_LEN, 4);
        push(K_WEN_LAT, 3);
        push(K_REN_LEN, 3);
        push(K_CNT, 4);
        vs_hi;
        cyc_wait(20);
        CAP_REQ = 0;
        vs_hi;
        cyc_wait(60);
        chk("capdrop_busy", int'(BUSY), 0);
        vs_hi;
        cyc_wait(60);
        chk("capdrop_idle", int'(BUSY), 0);
        CAP_REQ = 1;
        // CFG_DONE dropped during capture
        push(K_WRST_LAT, 3);
        push(K_WRST_LEN, 4);
        push(K_WEN_LAT, 21);
        vs_hi;
        cyc_wait(10);
        CFG_DONE = 0;
        @(posedge CLK_40M);
        @(negedge CLK_40M);
        chk("cfgabort_wen", int'(bus.OV_WEN), 0);
        chk("cfgabort_busy", int'(BUSY), 0);
        cyc_wait(10);
        CFG_DONE = 1;
        skip2;
        // CFG_DONE dropped during readout
        push(K_WRST_LAT, 3);
        push(K_WRST_LEN, 4);
        push(K_WEN_LAT, 3);
        push(K_REN_LEN, 3);
        push(K_CNT, 5);
        vs_hi;
        cyc_wait(60);
        vs_hi;
        CFG_DONE = 0;
        cyc_wait(60);
        chk("cfgread_cnt", int'(FRAME_CNT), 5);
        chk("cfgread_busy", int'(BUSY), 0);
        CFG_DONE = 1;
        skip2;
        // reset during WRST
        push(K_WRST_LAT, 3);
        push(K_WRST_LEN, 2);
        push(K_CNT, 0);
        @(posedge CLK_40M);
        #1 bus.OV_VSYNC = 1;
        vs_cyc = cyc;
        cyc_wait(4);
        RST = 1;
        bus.OV_VSYNC = 0;
        @(posedge CLK_40M);
        @(negedge CLK_40M);
        chk_rst("rst_wrst");
        cyc_wait(2);
        RST = 0;
        skip2;
        frame(1);
        // reset during READ
        push(K_WRST_LAT, 3);
        push(K_WRST_LEN, 4);
        push(K_WEN_LAT, 3);
        push(K_REN_LEN, 3);
        push(K_CNT, 0);
        vs_hi;
        cyc_wait(60);
        vs_hi;
        RST = 1;
        @(posedge CLK_40M);
        @(negedge CLK_40M);
        chk_rst("rst_read");
        cyc_wait(2);
        RST = 0;
        cyc_wait(40);
        skip2;
        for (int k = 1; k <= 17; k++) frame(k % 16);
        chk("wrap_cnt", int'(FRAME_CNT), 1);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ov7670_frame_arbiter.md
Name: ov7670_frame_arbiter

Overview:
Frame-level controller that sequences the OV7670 + AL422 FIFO camera path. It arms the FIFO write side for exactly one sensor frame, bounded by VSYNC. It then issues READ_EN to the FIFO read engine and waits for that frame's readout to finish before arming the next capture. Write and read of the single-frame FIFO are never active at the same time. The block sits between the SCCB configuration block, the camera pins and the FIFO-to-TX-cache reader.

Parameters:
SKIP_FRAMES, 2, VSYNC edges discarded after CFG_DONE rises (sensor settling); 0 disables skipping.
WRST_CYCLES, 4, CLK_40M cycles OV_WRST is held low before a capture.
ACK_TIMEOUT, 1024, cycles allowed for the reader to acknowledge READ_EN by pulling RD_FRAME low.
CNT_W, 16, width of FRAME_CNT.

Ports:
CLK_40M  in  1  system clock; single clock domain.
RST  in  1  synchronous, active-high reset.
CFG_DONE  in  1  sensor register configuration complete (level).
CAP_REQ  in  1  capture enable; while high, frames are captured back-to-back.
OV_VSYNC  in  1  camera VSYNC, asynchronous, high between frames.
RD_FRAME  in  1  reader status; high = idle/frame done, low = reading.
OV_WRST  out  1  FIFO write-pointer reset, active low.
OV_WEN  out  1  FIFO write enable, active high.
READ_EN  out  1  read request to the reader.
FRAME_CNT  out  CNT_W  completed (captured and read) frames; wraps.
ERR_TIMEOUT  out  1  sticky flag: reader failed to acknowledge.
BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST sampled high at a CLK_40M edge) forces: OV_WRST=1, OV_WEN=0, READ_EN=0, FRAME_CNT=0, ERR_TIMEOUT=0, BUSY=0, state=IDLE, skip_cnt=SKIP_FRAMES, sync flops=0. Reset overrides every state, including a capture or read in progress.
- VSYNC synchronisation:
  - OV_VSYNC passes through 2 flops (vs_s1, vs_s2) plus a delay flop vs_s3.
  - vs_rise = vs_s2 & ~vs_s3, a single-cycle pulse.
  - vs_rise is high in the 3rd cycle after OV_VSYNC is first sampled high.
- skip_cnt:
  - Reloads to SKIP_FRAMES whenever CFG_DONE=0.
  - While CFG_DONE=1 and skip_cnt!=0, each vs_rise decrements it, in any state.
  - Captures are only permitted when skip_cnt==0.
- States and transitions:
  - IDLE: all outputs inactive. Go to WAIT_VS when CFG_DONE=1, CAP_REQ=1 and skip_cnt==0.
  - WAIT_VS: wait for vs_rise, then go to WRST and load wrst_cnt=0. Return to IDLE if CFG_DONE=0 or CAP_REQ=0.
  - WRST: OV_WRST=0 for exactly WRST_CYCLES cycles. Then OV_WRST=1 and go to CAPTURE. CFG_DONE=0 aborts to IDLE with OV_WRST=1 in the next cycle.
  - CAPTURE: OV_WEN=1 from the first cycle in the state. On the next vs_rise, set OV_WEN=0 (registered, next cycle) and go to REQ. CAP_REQ falling does not abort the capture; the frame completes. CFG_DONE=0 aborts to IDLE with OV_WEN=0.
  - REQ: READ_EN=1 and the timeout counter increments.
    - RD_FRAME sampled 0: READ_EN=0 next cycle, go to READ.
    - Counter reaches ACK_TIMEOUT-1 with RD_FRAME still 1: READ_EN=0, ERR_TIMEOUT=1, go to IDLE; FRAME_CNT unchanged.
  - READ: OV_WEN=0 and READ_EN=0. On RD_FRAME sampled 1: FRAME_CNT += 1 (modulo 2^CNT_W), go to IDLE. CFG_DONE and CAP_REQ are ignored here, so a readout always completes.
- Mutual exclusion invariant: OV_WEN and READ_EN are never both 1. OV_WEN is never 1 while in REQ or READ.
- ERR_TIMEOUT is cleared only by RST.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Normal frame: SKIP_FRAMES=0, CFG_DONE=CAP_REQ=1, VSYNC period 2000 cycles, reader model drops RD_FRAME 2 cycles after READ_EN and raises it 500 cycles later -> OV_WRST low exactly 4 cycles starting 3-4 cycles after VSYNC rise; OV_WEN high until 3-4 cycles after next VSYNC rise; READ_EN high until RD_FRAME low; FRAME_CNT=1.
- Skip: SKIP_FRAMES=2, CFG_DONE rises -> first two VSYNC edges produce no OV_WRST/OV_WEN; the capture is armed on the 3rd edge.
- Timeout: reader holds RD_FRAME=1 -> READ_EN high exactly 1024 cycles, then ERR_TIMEOUT=1, state IDLE, FRAME_CNT unchanged. The next frame still captures normally.
- Aborts:
  - CAP_REQ dropped mid-CAPTURE -> frame finishes, read issued, FRAME_CNT increments, then block stays IDLE.
  - CFG_DONE dropped mid-CAPTURE -> OV_WEN=0 next cycle, IDLE.
  - CFG_DONE dropped during READ -> read completes.
- Wrap and exclusion: CNT_W=4, run 17 frames -> FRAME_CNT=1. Assertion throughout: never OV_WEN && READ_EN.
- Reset mid-operation: RST pulsed during WRST and during READ -> next cycle all outputs at reset values, skip_cnt reloaded, BUSY=0.
